// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter
//   Lets NUM_REQ client blocks share one SPI byte engine. A round-robin
//   arbiter grants one client at a time. The FSM then pulls that client's
//   chip select low and waits out a setup time. It pushes a burst of bytes
//   through the engine's start/done handshake and returns each received byte
//   to the client. After a hold time it raises chip select again.
//
// Ports
//   clk        system clock, everything on the rising edge
//   rst        synchronous reset, active-high
//   req        per-client request level, only looked at while idle
//   req_len    per-client burst length (LEN_W bits each, 0 means 1)
//   req_tx     per-client next transmit byte (DATA_W bits each)
//   gnt        one-hot grant, held for the whole transaction
//   tx_ack     one-cycle pulse, the granted client's req_tx was taken
//   rx_valid   one-cycle pulse, rx_data belongs to that client
//   rx_data    last received byte
//   cs_n       active-low chip selects, at most one low
//   eng_start  one-cycle start pulse to the SPI engine
//   eng_tx     byte handed to the engine alongside eng_start
//   eng_busy   engine busy, no start is issued while it is high
//   eng_done   engine finished a byte, eng_rx is valid
//   eng_rx     byte received by the engine

module spi_req_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 8,
  parameter int LEN_W    = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ*DATA_W-1:0] req_tx,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        tx_ack,
  output logic [NUM_REQ-1:0]        rx_valid,
  output logic [DATA_W-1:0]         rx_data,
  output logic [NUM_REQ-1:0]        cs_n,
  output logic                      eng_start,
  output logic [DATA_W-1:0]         eng_tx,
  input  logic                      eng_busy,
  input  logic                      eng_done,
  input  logic [DATA_W-1:0]         eng_rx
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = 8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  // The last setup cycle already launches the first byte, so cs_n low to
  // eng_start spans exactly CS_SETUP cycles. The same idea applies to the
  // hold: the cycle after the final eng_done counts as the first hold cycle.
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'((CS_HOLD >= 2) ? CS_HOLD - 2 : 0);
  localparam logic [IDX_W-1:0] PTR_INIT   = IDX_W'(NUM_REQ - 1);

  logic [2:0]         state;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   rr_ptr;
  logic [LEN_W-1:0]   rem;
  logic [CNT_W-1:0]   cnt;

  logic [IDX_W-1:0]   win;
  logic               found;
  int                 cand;
  logic [LEN_W-1:0]   win_len;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] idx_oh;
  logic [DATA_W-1:0]  sel_tx;

  // Round-robin pick: the first asserted request strictly after the last
  // owner, scanning cyclically. The last owner itself is checked last, so a
  // lone persistent requester still wins again.
  always_comb begin
    win   = rr_ptr;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr_ptr) + k) % NUM_REQ;
      if (!found && req[cand]) begin
        win   = IDX_W'(cand);
        found = 1'b1;
      end
    end
    win_len = req_len[win*LEN_W +: LEN_W];
    win_oh  = NUM_REQ'(1) << win;
    idx_oh  = NUM_REQ'(1) << idx;
    sel_tx  = req_tx[idx*DATA_W +: DATA_W];
  end

  // Transaction sequencer. Pulse outputs default low every cycle, so each
  // one can only be high for the single cycle after it was set.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      rr_ptr    <= PTR_INIT;
      rem       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      tx_ack    <= '0;
      rx_valid  <= '0;
      rx_data   <= '0;
      cs_n      <= '1;
      eng_start <= 1'b0;
      eng_tx    <= '0;
    end else begin
      eng_start <= 1'b0;
      tx_ack    <= '0;
      rx_valid  <= '0;
      case (state)
        S_IDLE: begin
          if (|req) begin
            idx   <= win;
            rem   <= (win_len == '0) ? LEN_W'(1) : win_len;
            gnt   <= win_oh;
            cs_n  <= ~win_oh;
            cnt   <= '0;
            state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            if (!eng_busy) begin
              eng_start <= 1'b1;
              eng_tx    <= sel_tx;
              tx_ack    <= idx_oh;
              state     <= S_WAIT;
            end else begin
              state <= S_START;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_START: begin
          if (!eng_busy) begin
            eng_start <= 1'b1;
            eng_tx    <= sel_tx;
            tx_ack    <= idx_oh;
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (eng_done) begin
            rx_data  <= eng_rx;
            rx_valid <= idx_oh;
            rem      <= rem - LEN_W'(1);
            if (rem == LEN_W'(1)) begin
              if (CS_HOLD == 1) begin
                cs_n   <= '1;
                gnt    <= '0;
                rr_ptr <= idx;
                state  <= S_GAP;
              end else begin
                cnt   <= '0;
                state <= S_HOLD;
              end
            end else begin
              state <= S_START;
            end
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            cs_n   <= '1;
            gnt    <= '0;
            rr_ptr <= idx;
            state  <= S_GAP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_GAP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter
//   Directed bench for spi_req_arbiter with default parameters (4 clients,
//   8-bit data, CS_SETUP=CS_HOLD=2). A small engine model answers every
//   eng_start with eng_done four cycles later and stays busy until then.
//   Ports: none (top level).

module tb_spi_req_arbiter;

  localparam int DONE_DLY = 4;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [31:0] req_tx;
  logic [3:0]  gnt;
  logic [3:0]  tx_ack;
  logic [3:0]  rx_valid;
  logic [7:0]  rx_data;
  logic [3:0]  cs_n;
  logic        eng_start;
  logic [7:0]  eng_tx;
  logic        eng_busy;
  logic        eng_done;
  logic [7:0]  eng_rx;

  int          checks;
  int          errors;
  int          cyc;
  int          starts;
  int          acks;
  int          rxv [4];
  int          eng_cnt;
  logic        busy_force;
  logic        prev_start;
  logic [3:0]  prev_gnt;
  logic [3:0]  prev_cs;
  logic        gap_seen;
  int          last_done_cyc;
  int          cs_rise_cyc;
  logic [7:0]  rx_pat;
  int          glog [$];
  int          exp_order [5];
  int          c0;

  spi_req_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_len   (req_len),
    .req_tx    (req_tx),
    .gnt       (gnt),
    .tx_ack    (tx_ack),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .cs_n      (cs_n),
    .eng_start (eng_start),
    .eng_tx    (eng_tx),
    .eng_busy  (eng_busy),
    .eng_done  (eng_done),
    .eng_rx    (eng_rx)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so a stuck run still ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  // Single comparison point: counts the check and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [15:0] lens);
    req     = r;
    req_len = lens;
  endtask

  function automatic int ohIndex(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic clearCounts();
    starts = 0;
    acks   = 0;
    for (int i = 0; i < 4; i++) rxv[i] = 0;
  endtask

  // Advance one cycle: sample outputs 1ns after the edge, run per-cycle
  // invariant checks and logging, then update the engine model inputs
  task automatic step();
    logic [3:0] gnt_n;
    @(posedge clk);
    #1;
    cyc++;
    gnt_n = ~gnt;
    checkOutput("cs_vs_gnt", cs_n, gnt_n);
    if (eng_start) begin
      starts++;
      checkOutput("start_consec", prev_start, 0);
      checkOutput("eng_tx", eng_tx, 8'h10 + ohIndex(gnt));
    end
    if (eng_start || tx_ack != 4'h0) begin
      checkOutput("ack_match", tx_ack, eng_start ? gnt : 4'h0);
    end
    if (tx_ack != 4'h0) acks++;
    if (rx_valid != 4'h0) begin
      for (int i = 0; i < 4; i++) rxv[i] += int'(rx_valid[i]);
      checkOutput("rx_data", rx_data, rx_pat);
    end
    if (gnt != 4'h0 && prev_gnt == 4'h0) begin
      if (glog.size() > 0) checkOutput("gap_before_grant", gap_seen, 1);
      glog.push_back(ohIndex(gnt));
      gap_seen = 1'b0;
    end
    if (cs_n == 4'hF) gap_seen = 1'b1;
    if (cs_n == 4'hF && prev_cs != 4'hF) cs_rise_cyc = cyc;
    prev_start = eng_start;
    prev_gnt   = gnt;
    prev_cs    = cs_n;

    eng_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        eng_done      = 1'b1;
        last_done_cyc = cyc;
      end
    end
    if (eng_start) eng_cnt = DONE_DLY;
    eng_busy = (eng_cnt > 0) || busy_force;
    eng_rx   = rx_pat;
  endtask

  // Wait for chip select to return high, then one more cycle into IDLE
  task automatic waitRelease(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (cs_n == 4'hF) break;
    end
    checkOutput("release", cs_n, 4'hF);
    step();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; eng_cnt = 0;
    rst = 1'b1; req = '0; req_len = '0;
    req_tx = {8'h13, 8'h12, 8'h11, 8'h10};
    eng_busy = 1'b0; eng_done = 1'b0; eng_rx = '0; rx_pat = '0;
    busy_force = 1'b0; prev_start = 1'b0; prev_gnt = '0; prev_cs = 4'hF;
    gap_seen = 1'b0; last_done_cyc = 0; cs_rise_cyc = 0;
    clearCounts();

    // 1: reset values, then idle with no request
    repeat (3) step();
    checkOutput("t1_rst_cs", cs_n, 4'hF);
    checkOutput("t1_rst_gnt", gnt, 4'h0);
    checkOutput("t1_rst_start", eng_start, 0);
    checkOutput("t1_rst_rxv", rx_valid, 4'h0);
    checkOutput("t1_rst_rxd", rx_data, 8'h00);
    rst = 1'b0;
    repeat (5) step();
    checkOutput("t1_idle_cs", cs_n, 4'hF);
    checkOutput("t1_idle_gnt", gnt, 4'h0);
    checkOutput("t1_idle_starts", starts, 0);

    // 2: client 0, three bytes; req dropped right after grant
    rx_pat = 8'hA5;
    clearCounts();
    applyStimulus(4'b0001, 16'h0003);
    step();
    checkOutput("t2_gnt", gnt, 4'b0001);
    checkOutput("t2_cs", cs_n, 4'b1110);
    applyStimulus(4'b0000, 16'h0003);
    step();
    checkOutput("t2_early_start", eng_start, 0);
    step();
    checkOutput("t2_start", eng_start, 1);
    checkOutput("t2_ack", tx_ack, 4'b0001);
    waitRelease(100);
    checkOutput("t2_starts", starts, 3);
    checkOutput("t2_acks", acks, 3);
    checkOutput("t2_rxv0", rxv[0], 3);
    checkOutput("t2_hold", cs_rise_cyc - last_done_cyc, 2);

    // 3: all four requesting from a fresh reset, single-byte bursts
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    clearCounts();
    glog.delete();
    exp_order = '{0, 1, 2, 3, 0};
    rx_pat = 8'h5A;
    applyStimulus(4'b1111, 16'h1111);
    for (int i = 0; i < 300; i++) begin
      step();
      if (glog.size() >= 5) break;
    end
    checkOutput("t3_grant_count", glog.size(), 5);
    for (int k = 0; k < glog.size() && k < 5; k++) begin
      checkOutput($sformatf("t3_order%0d", k), glog[k], exp_order[k]);
    end
    applyStimulus(4'b0000, 16'h1111);
    waitRelease(100);

    // 4: zero length on client 2 behaves as one byte
    clearCounts();
    glog.delete();
    rx_pat = 8'hC3;
    applyStimulus(4'b0100, 16'h0000);
    step();
    checkOutput("t4_gnt", gnt, 4'b0100);
    applyStimulus(4'b0000, 16'h0000);
    waitRelease(100);
    checkOutput("t4_starts", starts, 1);
    checkOutput("t4_rxv2", rxv[2], 1);
    checkOutput("t4_rxv_other", rxv[0] + rxv[1] + rxv[3], 0);

    // 5: engine busy for five cycles where the first start would go out
    clearCounts();
    rx_pat = 8'h96;
    applyStimulus(4'b1000, 16'h1000);
    step();
    checkOutput("t5_gnt", gnt, 4'b1000);
    applyStimulus(4'b0000, 16'h1000);
    busy_force = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput("t5_no_start_busy", eng_start, 0);
    end
    busy_force = 1'b0;
    step();
    checkOutput("t5_no_start_fall", eng_start, 0);
    step();
    checkOutput("t5_start", eng_start, 1);
    checkOutput("t5_ack", tx_ack, 4'b1000);
    waitRelease(100);
    checkOutput("t5_starts", starts, 1);
    checkOutput("t5_rxv3", rxv[3], 1);

    // 6: reset in the middle of a four-byte burst
    clearCounts();
    rx_pat = 8'h3C;
    applyStimulus(4'b0001, 16'h0004);
    step();
    checkOutput("t6_gnt", gnt, 4'b0001);
    applyStimulus(4'b0000, 16'h0004);
    for (int i = 0; i < 20; i++) begin
      step();
      if (eng_start) break;
    end
    checkOutput("t6_start_seen", eng_start, 1);
    step();
    rst = 1'b1;
    step();
    checkOutput("t6_rst_gnt", gnt, 4'h0);
    checkOutput("t6_rst_cs", cs_n, 4'hF);
    checkOutput("t6_rst_start", eng_start, 0);
    checkOutput("t6_rst_ack", tx_ack, 4'h0);
    checkOutput("t6_rst_rxv", rx_valid, 4'h0);
    checkOutput("t6_rst_rxd", rx_data, 8'h00);
    checkOutput("t6_rst_tx", eng_tx, 8'h00);
    rst = 1'b0;
    clearCounts();
    repeat (6) step();
    checkOutput("t6_stray_rxv", rxv[0] + rxv[1] + rxv[2] + rxv[3], 0);
    checkOutput("t6_stray_starts", starts, 0);
    applyStimulus(4'b0010, 16'h0020);
    step();
    checkOutput("t6_regrant", gnt, 4'b0010);
    checkOutput("t6_regrant_cs", cs_n, 4'b1101);
    applyStimulus(4'b0000, 16'h0020);
    waitRelease(100);
    checkOutput("t6_starts", starts, 2);
    checkOutput("t6_rxv1", rxv[1], 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
